// File: rtl/watch_pkg.sv
// Shared definitions for the watch set-mode controller: state/field
// encodings and a counter-width helper.
package watch_pkg;

    // Set-mode states; the field code presented to the display equals the state.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SEC  = 2'd1,
        ST_MIN  = 2'd2,
        ST_HOUR = 2'd3
    } state_t;

    localparam logic [1:0] FLD_NONE = 2'd0;
    localparam logic [1:0] FLD_SEC  = 2'd1;
    localparam logic [1:0] FLD_MIN  = 2'd2;
    localparam logic [1:0] FLD_HOUR = 2'd3;

    // Width of a counter covering 0..n-1; never narrower than one bit.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/watch_set_ctrl_btn_edge.sv
// btn_edge: 2-FF synchronizer for an asynchronous debounced button,
// followed by a rising-edge detector. Exports the synchronized level too.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    logic r_s1, r_s2, r_s3;

    // Two synchronizer flops plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: turns MODE/UP buttons into per-field increment pulses,
// with UP auto-repeat, idle timeout back to RUN and tick gating.
// Optional blink generator enabled by defining WATCH_SET_BLINK_EN.
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int REPEAT_CYCLES  = 10_000_000,
    parameter int TIMEOUT_CYCLES = 1_000_000_000,
    parameter int BLINK_CYCLES   = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_mode,
    input  logic       i_btn_up,
    output logic       o_run_sec,
    output logic       o_run_min,
    output logic       o_run_hour,
    output logic       o_tick_en,
    output logic [1:0] o_field,
    output logic       o_blink
);

    localparam int HW = cw(HOLD_CYCLES);
    localparam int RW = cw(REPEAT_CYCLES);
    localparam int IW = cw(TIMEOUT_CYCLES);

    logic w_mode_lvl, w_mode_rise, w_up_lvl, w_up_rise;

    btn_edge u_mode (.clk(clk), .rst(rst), .i_btn(i_btn_mode), .o_level(w_mode_lvl), .o_rise(w_mode_rise));
    btn_edge u_up   (.clk(clk), .rst(rst), .i_btn(i_btn_up),   .o_level(w_up_lvl),   .o_rise(w_up_rise));

    state_t          r_state, w_next;
    logic [HW-1:0]   r_hold, w_hold;
    logic [RW-1:0]   r_rep, w_rep;
    logic [IW-1:0]   r_idle, w_idle;
    logic            r_rep_act, w_rep_act;   // hold phase done, now repeating
    logic            r_up_blk, w_up_blk;     // UP held across a MODE step: ignore until released
    logic            w_pulse;
    logic            r_run_sec, r_run_min, r_run_hour, r_tick_en;

    // State register and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_hold    <= '0;
            r_rep     <= '0;
            r_idle    <= '0;
            r_rep_act <= 1'b0;
            r_up_blk  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_hold    <= w_hold;
            r_rep     <= w_rep;
            r_idle    <= w_idle;
            r_rep_act <= w_rep_act;
            r_up_blk  <= w_up_blk;
        end
    end

    // Next state, auto-repeat, idle timeout; MODE beats UP, UP edge beats timeout.
    always_comb begin
        w_next    = r_state;
        w_hold    = r_hold;
        w_rep     = r_rep;
        w_idle    = r_idle;
        w_rep_act = r_rep_act;
        w_up_blk  = r_up_blk;
        w_pulse   = 1'b0;
        if (!w_up_lvl) begin
            w_hold    = '0;
            w_rep     = '0;
            w_rep_act = 1'b0;
            w_up_blk  = 1'b0;
        end
        if (w_mode_rise) begin
            unique case (r_state)
                ST_RUN:  w_next = ST_SEC;
                ST_SEC:  w_next = ST_MIN;
                ST_MIN:  w_next = ST_HOUR;
                default: w_next = ST_RUN;
            endcase
            w_hold    = '0;
            w_rep     = '0;
            w_rep_act = 1'b0;
            w_up_blk  = w_up_lvl;
            w_idle    = '0;
        end else if (r_state != ST_RUN) begin
            if (w_up_rise) begin
                w_pulse   = 1'b1;
                w_hold    = '0;
                w_rep     = '0;
                w_rep_act = 1'b0;
            end else if (w_up_lvl && !r_up_blk) begin
                if (!r_rep_act) begin
                    if (r_hold == HW'(HOLD_CYCLES - 1)) begin
                        w_pulse   = 1'b1;
                        w_rep_act = 1'b1;
                    end else begin
                        w_hold = r_hold + HW'(1);
                    end
                end else if (r_rep == RW'(REPEAT_CYCLES - 1)) begin
                    w_pulse = 1'b1;
                    w_rep   = '0;
                end else begin
                    w_rep = r_rep + RW'(1);
                end
            end
            if (w_pulse) begin
                w_idle = '0;
            end else if (r_idle == IW'(TIMEOUT_CYCLES - 1)) begin
                w_idle = '0;
                w_next = ST_RUN;
            end else begin
                w_idle = r_idle + IW'(1);
            end
        end else begin
            w_hold    = '0;
            w_rep     = '0;
            w_rep_act = 1'b0;
            w_idle    = '0;
        end
    end

    // Registered pulse outputs and tick gate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_sec  <= 1'b0;
            r_run_min  <= 1'b0;
            r_run_hour <= 1'b0;
            r_tick_en  <= 1'b1;
        end else begin
            r_run_sec  <= w_pulse && (r_state == ST_SEC);
            r_run_min  <= w_pulse && (r_state == ST_MIN);
            r_run_hour <= w_pulse && (r_state == ST_HOUR);
            r_tick_en  <= (w_next == ST_RUN);
        end
    end

    assign o_run_sec  = r_run_sec;
    assign o_run_min  = r_run_min;
    assign o_run_hour = r_run_hour;
    assign o_tick_en  = r_tick_en;
    assign o_field    = r_state;

`ifdef WATCH_SET_BLINK_EN
    localparam int BW = cw(BLINK_CYCLES);
    logic [BW-1:0] r_bcnt;
    logic          r_blink;

    // Blink phase toggles every BLINK_CYCLES while setting; held low in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt  <= '0;
            r_blink <= 1'b0;
        end else if (w_next == ST_RUN) begin
            r_bcnt  <= '0;
            r_blink <= 1'b0;
        end else if (r_bcnt == BW'(BLINK_CYCLES - 1)) begin
            r_bcnt  <= '0;
            r_blink <= ~r_blink;
        end else begin
            r_bcnt  <= r_bcnt + BW'(1);
        end
    end

    assign o_blink = r_blink;
`else
    assign o_blink = 1'b0;
`endif

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Scoreboard bench for watch_set_ctrl (HOLD=8, REPEAT=4, TIMEOUT=32, BLINK=3).
module tb_watch_set_ctrl;

    logic       clk = 1'b0;
    logic       rst, i_btn_mode, i_btn_up;
    logic       o_run_sec, o_run_min, o_run_hour, o_tick_en, o_blink;
    logic [1:0] o_field;

    watch_set_ctrl #(
        .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .TIMEOUT_CYCLES(32), .BLINK_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .i_btn_mode(i_btn_mode), .i_btn_up(i_btn_up),
        .o_run_sec(o_run_sec), .o_run_min(o_run_min), .o_run_hour(o_run_hour),
        .o_tick_en(o_tick_en), .o_field(o_field), .o_blink(o_blink)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] fld;
        int         c;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor: every observed pulse is matched against the next expected one.
    always @(negedge clk) begin
        if (!rst && (o_run_sec || o_run_min || o_run_hour)) begin
            logic [1:0] f;
            exp_t e;
            f = o_run_hour ? 2'd3 : (o_run_min ? 2'd2 : 2'd1);
            n_cmp++;
            if ((32'(o_run_sec) + 32'(o_run_min) + 32'(o_run_hour)) != 1) begin
                n_bad++;
                $display("FAIL onehot: sec=%0b min=%0b hour=%0b", o_run_sec, o_run_min, o_run_hour);
            end
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: field %0d at cyc %0d, none expected", f, cyc);
            end else begin
                e = q.pop_front();
                n_cmp++;
                if (f !== e.fld || cyc != e.c) begin
                    n_bad++;
                    $display("FAIL pulse: field %0d at cyc %0d, expected field %0d at cyc %0d", f, cyc, e.fld, e.c);
                end
            end
        end
    end

    task automatic press(input logic m, input logic u, input int len);
        i_btn_mode = m;
        i_btn_up   = u;
        repeat (len) @(negedge clk);
        i_btn_mode = 1'b0;
        i_btn_up   = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic mode_step(input logic [1:0] exp_fld, input string nm);
        press(1'b1, 1'b0, 2);
        repeat (4) @(negedge clk);
        chk(nm, o_field, exp_fld);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int m, m0, mu, tog;
        logic prev;
        rst = 1'b1; i_btn_mode = 1'b0; i_btn_up = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tick_en", o_tick_en, 1);
        chk("rst_field", o_field, 0);
        chk("rst_pulses", {o_run_sec, o_run_min, o_run_hour}, 0);
        chk("rst_blink", o_blink, 0);
        rst = 1'b0;
        @(negedge clk);

        // UP in RUN is ignored
        press(1'b0, 1'b1, 2);
        repeat (6) @(negedge clk);
        chk("run_field", o_field, 0);
        chk("run_tick_en", o_tick_en, 1);

        // SET_SEC: single press gives one pulse three cycles later
        mode_step(2'd1, "sec_field");
        chk("sec_tick_en", o_tick_en, 0);
`ifndef WATCH_SET_BLINK_EN
        chk("blink_off", o_blink, 0);
`endif
        m = cyc;
        q.push_back('{2'd1, m + 3});
        press(1'b0, 1'b1, 2);
        repeat (6) @(negedge clk);

        // SET_MIN: 20-cycle hold -> edge pulse + repeats at hold counts 8, 12, 16
        mode_step(2'd2, "min_field");
        m = cyc;
        q.push_back('{2'd2, m + 3});
        q.push_back('{2'd2, m + 11});
        q.push_back('{2'd2, m + 15});
        q.push_back('{2'd2, m + 19});
        press(1'b0, 1'b1, 20);
        repeat (6) @(negedge clk);

        // Back to RUN, then a full MODE cycle
        mode_step(2'd3, "hour_field");
        mode_step(2'd0, "back_run_field");
        chk("back_run_tick_en", o_tick_en, 1);
        for (int i = 0; i < 4; i++) begin
            mode_step(2'((i + 1) % 4), "cycle_field");
            chk("cycle_tick_en", o_tick_en, (i == 3) ? 1 : 0);
        end

        // MODE and UP together: state advances, no pulse
        press(1'b1, 1'b1, 2);
        repeat (6) @(negedge clk);
        chk("both_field", o_field, 1);

        // SET_HOUR idle timeout, restarted by an UP press 20 cycles in
        mode_step(2'd2, "to_min_field");
        m0 = cyc;
        press(1'b1, 1'b0, 2);
        wait_until(m0 + 6);
        chk("idle_hour_field", o_field, 3);
        wait_until(m0 + 20);
        mu = cyc;
        q.push_back('{2'd3, mu + 3});
        press(1'b0, 1'b1, 2);
        wait_until(mu + 34);
        chk("idle_restart_field", o_field, 3);
        wait_until(mu + 35);
        chk("timeout_field", o_field, 0);
        chk("timeout_tick_en", o_tick_en, 1);

        // Reset in the middle of an auto-repeat hold
        mode_step(2'd1, "rh_field");
`ifdef WATCH_SET_BLINK_EN
        tog = 0;
        prev = o_blink;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (o_blink !== prev) tog++;
            prev = o_blink;
        end
        chk("blink_toggles", tog, 3);
`endif
        mu = cyc;
        q.push_back('{2'd1, mu + 3});
        q.push_back('{2'd1, mu + 11});
        i_btn_up = 1'b1;
        wait_until(mu + 13);
        rst = 1'b1;
        #1;
        chk("mid_rst_pulses", {o_run_sec, o_run_min, o_run_hour}, 0);
        chk("mid_rst_field", o_field, 0);
        chk("mid_rst_tick_en", o_tick_en, 1);
        chk("mid_rst_blink", o_blink, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        i_btn_up = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_field", o_field, 0);
        chk("post_rst_tick_en", o_tick_en, 1);

        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
